// File: rtl/bird_physics.sv
// bird_physics: per-frame sprite motion engine for the side-scroller.
// Integrates gravity into a signed vertical velocity, flaps on the rising edge
// of the jump key, enforces ceiling/floor/right-edge bounds and runs the
// IDLE/PLAY/DEAD/WIN game state machine.
// Optional feature macro: BIRD_VCLAMP_EN limits downward velocity to +VMAX.
//
// state  | meaning
// S_IDLE | waiting at start position for the first flap
// S_PLAY | sprite moving; X advances, Y follows VelY
// S_DEAD | collision, floor or ceiling hit; frozen until next flap
// S_WIN  | right edge reached; frozen until next flap
module bird_physics #(
  parameter int          W        = 10,
  parameter int          X_START  = 30,
  parameter int          Y_START  = 200,
  parameter int          Y_MIN    = 127,
  parameter int          Y_MAX    = 260,
  parameter int          X_MAX    = 639,
  parameter int          SIZE     = 31,
  parameter int          X_STEP   = 1,
  parameter int          GRAVITY  = 1,
  parameter int          JUMP_VEL = -6,
  parameter int          VMAX     = 4,
  parameter logic [7:0]  JUMP_KEY = 8'h1A
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   keycode,
  input  logic         collide,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic [W-1:0] VelY,
  output logic [1:0]   state,
  output logic         gameover,
  output logic         gamewin
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_WIN  = 2'd3
  } state_t;

`ifdef BIRD_VCLAMP_EN
  localparam bit VCLAMP_EN = 1'b1;
`else
  localparam bit VCLAMP_EN = 1'b0;
`endif

  // Internal arithmetic runs two bits wider than W so sums never wrap.
  localparam int WE        = W + 2;
  localparam int VSAT_WIDE = (2 ** (W - 1)) - 1;
  localparam int VSAT      = (VCLAMP_EN && (VMAX < VSAT_WIDE)) ? VMAX : VSAT_WIDE;

  localparam logic signed [WE-1:0] L_VSAT   = WE'(VSAT);
  localparam logic signed [WE-1:0] L_FLOOR  = WE'(Y_MAX - SIZE);
  localparam logic signed [WE-1:0] L_CEIL   = WE'(Y_MIN);
  localparam logic signed [WE-1:0] L_GRAV   = WE'(GRAVITY);
  localparam logic        [WE-1:0] L_XSTEP  = WE'(X_STEP);
  localparam logic        [WE-1:0] L_XWIN   = WE'(X_MAX - SIZE);
  localparam logic        [W-1:0]  L_JUMP   = W'(JUMP_VEL);
  localparam logic        [W-1:0]  L_XSTART = W'(X_START);
  localparam logic        [W-1:0]  L_YSTART = W'(Y_START);

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_ball_x, w_ball_x_nxt;
  logic [W-1:0]   r_ball_y, w_ball_y_nxt;
  logic [W-1:0]   r_vel_y,  w_vel_y_nxt;
  logic           r_key_prev;

  logic                 w_key_hit;
  logic                 w_flap;
  logic signed [WE-1:0] w_vel_ext;
  logic signed [WE-1:0] w_y_ext;
  logic signed [WE-1:0] w_vel_sum;
  logic        [W-1:0]  w_vel_grav;
  logic        [WE-1:0] w_x_adv;
  logic                 w_hit_floor;
  logic                 w_hit_ceil;
  logic                 w_hit_right;

  assign w_key_hit  = (keycode == JUMP_KEY);
  assign w_flap     = w_key_hit & ~r_key_prev;

  assign w_vel_ext  = {{2{r_vel_y[W-1]}}, r_vel_y};
  assign w_y_ext    = $signed({2'b00, r_ball_y}) + w_vel_ext;
  assign w_vel_sum  = w_vel_ext + L_GRAV;
  assign w_vel_grav = (w_vel_sum > L_VSAT) ? L_VSAT[W-1:0] : w_vel_sum[W-1:0];
  assign w_x_adv    = {2'b00, r_ball_x} + L_XSTEP;

  // Bottom edge is Y+SIZE, so the floor test is folded into Y_MAX-SIZE.
  assign w_hit_floor = (w_y_ext >= L_FLOOR);
  assign w_hit_ceil  = (w_y_ext <= L_CEIL);
  assign w_hit_right = (w_x_adv >= L_XWIN);

  // State, position, velocity and key history registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_ball_x   <= L_XSTART;
      r_ball_y   <= L_YSTART;
      r_vel_y    <= '0;
      r_key_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ball_x   <= w_ball_x_nxt;
      r_ball_y   <= w_ball_y_nxt;
      r_vel_y    <= w_vel_y_nxt;
      r_key_prev <= w_key_hit;
    end
  end

  // Next-state and motion update; death outranks win, win outranks flap.
  always_comb begin
    w_state_nxt  = r_state;
    w_ball_x_nxt = r_ball_x;
    w_ball_y_nxt = r_ball_y;
    w_vel_y_nxt  = r_vel_y;
    case (r_state)
      S_IDLE: begin
        w_ball_x_nxt = L_XSTART;
        w_ball_y_nxt = L_YSTART;
        w_vel_y_nxt  = '0;
        if (w_flap) begin
          w_state_nxt = S_PLAY;
          w_vel_y_nxt = L_JUMP;
        end
      end
      S_PLAY: begin
        w_ball_x_nxt = w_hit_right ? L_XWIN[W-1:0] : w_x_adv[W-1:0];
        w_vel_y_nxt  = w_flap ? L_JUMP : w_vel_grav;
        if (w_hit_floor)
          w_ball_y_nxt = L_FLOOR[W-1:0];
        else if (w_hit_ceil)
          w_ball_y_nxt = L_CEIL[W-1:0];
        else
          w_ball_y_nxt = w_y_ext[W-1:0];
        if (w_hit_floor || w_hit_ceil || collide) begin
          w_state_nxt = S_DEAD;
          w_vel_y_nxt = '0;
        end else if (w_hit_right) begin
          w_state_nxt = S_WIN;
          w_vel_y_nxt = '0;
        end
      end
      default: begin
        w_vel_y_nxt = '0;
        if (w_flap) begin
          w_state_nxt  = S_IDLE;
          w_ball_x_nxt = L_XSTART;
          w_ball_y_nxt = L_YSTART;
        end
      end
    endcase
  end

  assign BallX    = r_ball_x;
  assign BallY    = r_ball_y;
  assign BallS    = W'(SIZE);
  assign VelY     = r_vel_y;
  assign state    = r_state;
  assign gameover = (r_state == S_DEAD);
  assign gamewin  = (r_state == S_WIN);

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: reset, single flap trajectory, free fall,
// ceiling death, collide-with-flap, restart, right-edge win, async reset.
module tb_bird_physics;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic       collide   = 1'b0;
  logic [7:0] keycode2  = 8'h00;

  logic [9:0] BallX, BallY, BallS, VelY;
  logic [1:0] state;
  logic       gameover, gamewin;

  logic [9:0] BallX2, BallY2, BallS2, VelY2;
  logic [1:0] state2;
  logic       gameover2, gamewin2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 frame_clk = ~frame_clk;

  bird_physics dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .collide(collide),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .VelY(VelY),
    .state(state), .gameover(gameover), .gamewin(gamewin)
  );

  bird_physics #(.X_MAX(80)) dut_win (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode2), .collide(1'b0),
    .BallX(BallX2), .BallY(BallY2), .BallS(BallS2), .VelY(VelY2),
    .state(state2), .gameover(gameover2), .gamewin(gamewin2)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    keycode  = 8'h00;
    keycode2 = 8'h00;
    collide  = 1'b0;
    Reset    = 1'b1;
    @(negedge frame_clk);
    Reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (BallX !== 10'd30) $display("FAIL reset_x: got %0d want 30", BallX); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd200) $display("FAIL reset_y: got %0d want 200", BallY); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'd0) $display("FAIL reset_vel: got %0d want 0", $signed(VelY)); else pass_cnt++;
    chk_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
    chk_cnt++; if (gameover !== 1'b0) $display("FAIL reset_gameover: got %0b want 0", gameover); else pass_cnt++;
    chk_cnt++; if (gamewin !== 1'b0) $display("FAIL reset_gamewin: got %0b want 0", gamewin); else pass_cnt++;
    chk_cnt++; if (BallS !== 10'd31) $display("FAIL ball_size: got %0d want 31", BallS); else pass_cnt++;
  endtask

  task automatic test_single_flap();
    int ey[4] = '{194, 189, 185, 182};
    int ev[4] = '{-5, -4, -3, -2};
    do_reset();
    keycode = 8'h1A;
    tick();
    chk_cnt++; if (state !== 2'd1) $display("FAIL flap_state: got %0d want 1", state); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'h3FA) $display("FAIL flap_vel: got %0d want -6", $signed(VelY)); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd200) $display("FAIL flap_y_hold: got %0d want 200", BallY); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cnt++; if (BallY !== 10'(ey[i])) $display("FAIL held_y[%0d]: got %0d want %0d", i, BallY, ey[i]); else pass_cnt++;
      chk_cnt++; if (VelY !== 10'(ev[i])) $display("FAIL held_vel[%0d]: got %0d want %0d", i, $signed(VelY), ev[i]); else pass_cnt++;
    end
    keycode = 8'h00;
  endtask

  task automatic test_free_fall();
    int n;
    int vmax;
    do_reset();
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    n = 0;
    vmax = -1000;
    while (state == 2'd1 && n < 60) begin
      tick();
      n++;
      if ($signed(VelY) > vmax) vmax = $signed(VelY);
    end
    chk_cnt++; if (state !== 2'd2) $display("FAIL fall_state: got %0d want 2 after %0d frames", state, n); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd229) $display("FAIL fall_y: got %0d want 229", BallY); else pass_cnt++;
    chk_cnt++; if (gameover !== 1'b1) $display("FAIL fall_gameover: got %0b want 1", gameover); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'd0) $display("FAIL fall_vel_zero: got %0d want 0", $signed(VelY)); else pass_cnt++;
`ifdef BIRD_VCLAMP_EN
    chk_cnt++; if (vmax > 4) $display("FAIL fall_vmax: got %0d want <=4", vmax); else pass_cnt++;
`else
    chk_cnt++; if (vmax != 10) $display("FAIL fall_vmax: got %0d want 10", vmax); else pass_cnt++;
    chk_cnt++; if (n != 17) $display("FAIL fall_frames: got %0d want 17", n); else pass_cnt++;
`endif
  endtask

  task automatic test_ceiling();
    int n;
    do_reset();
    n = 0;
    while (state != 2'd2 && n < 60) begin
      keycode = (n % 2 == 0) ? 8'h1A : 8'h00;
      tick();
      n++;
    end
    keycode = 8'h00;
    chk_cnt++; if (state !== 2'd2) $display("FAIL ceil_state: got %0d want 2", state); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd127) $display("FAIL ceil_y: got %0d want 127", BallY); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'd0) $display("FAIL ceil_vel: got %0d want 0", $signed(VelY)); else pass_cnt++;
    chk_cnt++; if (n != 15) $display("FAIL ceil_frames: got %0d want 15", n); else pass_cnt++;
  endtask

  task automatic test_collide_flap();
    do_reset();
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    tick();
    keycode = 8'h1A;
    collide = 1'b1;
    tick();
    collide = 1'b0;
    chk_cnt++; if (state !== 2'd2) $display("FAIL collide_state: got %0d want 2", state); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'd0) $display("FAIL collide_vel: got %0d want 0", $signed(VelY)); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd189) $display("FAIL collide_y: got %0d want 189", BallY); else pass_cnt++;
    chk_cnt++; if (BallX !== 10'd32) $display("FAIL collide_x: got %0d want 32", BallX); else pass_cnt++;
  endtask

  task automatic test_restart();
    // Key is still held from the dying frame: no edge, stay DEAD.
    tick();
    chk_cnt++; if (state !== 2'd2) $display("FAIL dead_hold_state: got %0d want 2", state); else pass_cnt++;
    keycode = 8'h00;
    tick();
    keycode = 8'h1A;
    tick();
    chk_cnt++; if (state !== 2'd0) $display("FAIL restart_state: got %0d want 0", state); else pass_cnt++;
    chk_cnt++; if (BallX !== 10'd30) $display("FAIL restart_x: got %0d want 30", BallX); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd200) $display("FAIL restart_y: got %0d want 200", BallY); else pass_cnt++;
    chk_cnt++; if (gameover !== 1'b0) $display("FAIL restart_gameover: got %0b want 0", gameover); else pass_cnt++;
    keycode = 8'h00;
    tick();
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    chk_cnt++; if (state !== 2'd1) $display("FAIL replay_state: got %0d want 1", state); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'h3FA) $display("FAIL replay_vel: got %0d want -6", $signed(VelY)); else pass_cnt++;
  endtask

  task automatic test_win();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      keycode2 = (k == 0 || k == 12) ? 8'h1A : 8'h00;
      tick();
      if (k == 18) begin
        chk_cnt++; if (BallX2 !== 10'd48) $display("FAIL prewin_x: got %0d want 48", BallX2); else pass_cnt++;
        chk_cnt++; if (state2 !== 2'd1) $display("FAIL prewin_state: got %0d want 1", state2); else pass_cnt++;
      end
    end
    keycode2 = 8'h00;
    chk_cnt++; if (BallX2 !== 10'd49) $display("FAIL win_x: got %0d want 49", BallX2); else pass_cnt++;
    chk_cnt++; if (gamewin2 !== 1'b1) $display("FAIL win_flag: got %0b want 1", gamewin2); else pass_cnt++;
    chk_cnt++; if (state2 !== 2'd3) $display("FAIL win_state: got %0d want 3", state2); else pass_cnt++;
    chk_cnt++; if (gameover2 !== 1'b0) $display("FAIL win_gameover: got %0b want 0", gameover2); else pass_cnt++;
    chk_cnt++; if (BallY2 !== 10'd173) $display("FAIL win_y: got %0d want 173", BallY2); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    tick();
    tick();
    tick();
    chk_cnt++; if (BallX !== 10'd33) $display("FAIL pre_reset_x: got %0d want 33", BallX); else pass_cnt++;
    #1;
    Reset = 1'b1;
    #1;
    chk_cnt++; if (BallX !== 10'd30) $display("FAIL async_x: got %0d want 30", BallX); else pass_cnt++;
    chk_cnt++; if (BallY !== 10'd200) $display("FAIL async_y: got %0d want 200", BallY); else pass_cnt++;
    chk_cnt++; if (VelY !== 10'd0) $display("FAIL async_vel: got %0d want 0", $signed(VelY)); else pass_cnt++;
    chk_cnt++; if (state !== 2'd0) $display("FAIL async_state: got %0d want 0", state); else pass_cnt++;
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_flap();
    test_free_fall();
    test_ceiling();
    test_collide_flap();
    test_restart();
    test_win();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
